// File: rtl/data_store_buffer.sv
// rtl/data_store_buffer.sv - posted-store FIFO with forwarding in front of a slow 16-word RAM
module data_store_buffer #(
  parameter int DEPTH         = 4,
  parameter int WRITE_LATENCY = 2,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [31:0]             mem_write_data,
  output logic [31:0]             mem_read_data,
  output logic                    stall,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  pending_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = (WRITE_LATENCY > 1) ? $clog2(WRITE_LATENCY) : 1;
  localparam int RW = 1 << ADDR_WIDTH;
  localparam logic [WW-1:0] WCNT_RELOAD = WW'(WRITE_LATENCY - 1);

  typedef enum logic {IDLE, WRITING} state_t;

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [31:0]           data_q [DEPTH];
  logic [31:0]           data_d [DEPTH];
  logic [31:0]           ram_q  [RW];
  logic [31:0]           ram_d  [RW];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [WW-1:0]         wcnt_q, wcnt_d;
  state_t                state_q, state_d;

  logic                  push;
  logic                  pop;
  logic                  fwd_hit;
  logic [31:0]           fwd_data;
  logic [PW-1:0]         fwd_idx;

  // Accept/refuse decision; stall looks only at the occupancy before this edge
  always_comb begin
    stall = mem_write && (count_q == CW'(DEPTH));
    push  = mem_write && !stall;
    pop   = (state_q == WRITING) && (wcnt_q == '0);
  end

  // Next-state for FIFO, RAM commit and the drain FSM
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    ram_d   = ram_q;
    head_d  = head_q;
    tail_d  = tail_q;
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (push) begin
      addr_d[tail_q] = address;
      data_d[tail_q] = mem_write_data;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      ram_d[addr_q[head_q]] = data_q[head_q];
      head_d                = head_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    case (state_q)
      IDLE: begin
        // An entry pushed on this same edge is not counted yet
        if (count_q != '0) begin
          state_d = WRITING;
          wcnt_d  = WCNT_RELOAD;
        end
      end
      WRITING: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WW'(1);
        end else if (count_d != '0) begin
          wcnt_d = WCNT_RELOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Youngest matching entry wins: scan oldest to youngest, later hits override
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == address)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  // Load data and status outputs
  always_comb begin
    if (!mem_read)    mem_read_data = '0;
    else if (fwd_hit) mem_read_data = fwd_data;
    else              mem_read_data = ram_q[address];
    busy          = (count_q != '0) || (state_q == WRITING);
    pending_count = count_q;
  end

  // State registers; reset wipes RAM and discards pending stores
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      addr_q  <= '{default: '0};
      data_q  <= '{default: '0};
      ram_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      wcnt_q  <= '0;
      state_q <= IDLE;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      ram_q   <= ram_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      wcnt_q  <= wcnt_d;
      state_q <= state_d;
    end
  end

endmodule
